// File: rtl/seg_disp_arbiter_pkg.sv
// Shared definitions for the seven-segment display arbiter.
package seg_disp_arbiter_pkg;

  // 1 s at 12 MHz; also the clkdiv reference period
  localparam int HOLD_CYCLES_DEF = 12_000_000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN    = 2'd1,
    ST_LINGER = 2'd2
  } st_e;

endpackage

// File: rtl/seg_disp_arbiter_rr_pick.sv
// Round-robin picker: first set request scanning start, start+1, ... mod NUM_REQ,
// optionally skipping one index (the current owner during preemption).
module seg_disp_arbiter_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int OWN_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWN_W-1:0]   start,
  input  logic               excl_en,
  input  logic [OWN_W-1:0]   excl_idx,
  output logic               found,
  output logic [OWN_W-1:0]   win
);

  localparam int              SW  = OWN_W + 1;
  localparam logic [SW-1:0]   N_S = SW'(NUM_REQ);

  logic [NUM_REQ-1:0] cand;
  logic [SW-1:0]      pos;

  // mask out the excluded requester
  always_comb begin
    cand = req;
    if (excl_en) cand[excl_idx] = 1'b0;
  end

  // scan from the far end so the candidate closest to start wins last
  always_comb begin
    found = 1'b0;
    win   = '0;
    pos   = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      pos = {1'b0, start} + SW'(k);
      if (pos >= N_S) pos = pos - N_S;
      if (cand[pos[OWN_W-1:0]]) begin
        found = 1'b1;
        win   = pos[OWN_W-1:0];
      end
    end
  end

endmodule

// File: rtl/seg_disp_arbiter.sv
// Round-robin owner of the 2-digit seven-segment display with a minimum
// visible hold time per owner and a linger phase after early release.
module seg_disp_arbiter
  import seg_disp_arbiter_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int HOLD_CYCLES = HOLD_CYCLES_DEF,
  localparam int OWN_W       = $clog2(NUM_REQ),
  localparam int CNT_W       = $clog2(HOLD_CYCLES+1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [OWN_W-1:0]     owner,
  output logic [7:0]           disp_value,
  output logic                 disp_valid
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);
  localparam logic [OWN_W-1:0] LAST_IDX = OWN_W'(NUM_REQ-1);

  st_e                      state;
  logic [OWN_W-1:0]         rr_ptr;
  logic [CNT_W-1:0]         hold_cnt;
  logic [NUM_REQ-1:0][7:0]  req_bytes;
  logic                     pick_found;
  logic [OWN_W-1:0]         pick_idx;
  logic [OWN_W-1:0]         pick_nxt;
  logic                     expired;
  logic                     own_req;
  logic                     take;
  logic                     drop;

  assign req_bytes = req_data;
  assign expired   = (hold_cnt == HOLD_MAX);
  assign own_req   = req[owner];
  assign pick_nxt  = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;

  // while owning, the owner never competes against itself
  seg_disp_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req      (req),
    .start    (rr_ptr),
    .excl_en  (state == ST_OWN),
    .excl_idx (owner),
    .found    (pick_found),
    .win      (pick_idx)
  );

  // take: hand the display to pick_idx; drop: go idle with nothing shown
  always_comb begin
    take = 1'b0;
    drop = 1'b0;
    unique case (state)
      ST_IDLE:   take = pick_found;
      ST_OWN: begin
        take = expired & pick_found;
        drop = expired & ~pick_found & ~own_req;
      end
      ST_LINGER: begin
        take = expired & pick_found;
        drop = expired & ~pick_found;
      end
      default: drop = 1'b1;
    endcase
  end

  // ownership FSM with registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      grant      <= '0;
      owner      <= '0;
      disp_value <= 8'h00;
      disp_valid <= 1'b0;
      rr_ptr     <= '0;
      hold_cnt   <= '0;
    end else if (take) begin
      state      <= ST_OWN;
      grant      <= NUM_REQ'(1) << pick_idx;
      owner      <= pick_idx;
      disp_value <= req_bytes[pick_idx];
      disp_valid <= 1'b1;
      rr_ptr     <= pick_nxt;
      hold_cnt   <= '0;
    end else if (drop) begin
      state      <= ST_IDLE;
      grant      <= '0;
      disp_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: disp_valid <= 1'b0;
        ST_OWN: begin
          if (!expired) hold_cnt <= hold_cnt + 1'b1;
          if (own_req) begin
            disp_value <= req_bytes[owner];
          end else begin
            state <= ST_LINGER;
            grant <= '0;
          end
        end
        ST_LINGER: hold_cnt <= hold_cnt + 1'b1;
        default:   state    <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Randomized bench for seg_disp_arbiter against an ownership/age reference model.
module tb_seg_disp_arbiter;

  localparam int N = 4;
  localparam int H = 4;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   grant;
  logic [1:0]     owner;
  logic [7:0]     disp_value;
  logic           disp_valid;

  always #5 CLK = ~CLK;

  seg_disp_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(H)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .owner      (owner),
    .disp_value (disp_value),
    .disp_valid (disp_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // reference model: who owns, how long ago it was granted, whether released
  int        m_have, m_rel, m_own, m_age, m_ptr;
  logic [7:0] m_val;
  logic       m_vld;

  function automatic int req_bit(input logic [N-1:0] r, input int i);
    return int'((r >> i) & 1);
  endfunction

  function automatic logic [7:0] byte_of(input logic [8*N-1:0] d, input int i);
    return 8'(d >> (8*i));
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int start, input int excl);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (req_bit(r, j) == 1 && j != excl) return j;
    end
    return -1;
  endfunction

  task grab(input int w);
    m_have = 1; m_rel = 0; m_own = w; m_age = 0;
    m_val = byte_of(req_data, w); m_vld = 1'b1;
    m_ptr = (w + 1) % N;
  endtask

  always @(posedge CLK) begin : model
    int w;
    if (RST) begin
      m_have = 0; m_rel = 0; m_own = 0; m_age = 0; m_ptr = 0;
      m_val = 8'h00; m_vld = 1'b0;
    end else if (m_have == 0) begin
      w = pick(req, m_ptr, -1);
      if (w >= 0) grab(w); else m_vld = 1'b0;
    end else if (m_rel == 1) begin
      if (m_age >= H) begin
        w = pick(req, m_ptr, -1);
        if (w >= 0) grab(w);
        else begin m_have = 0; m_vld = 1'b0; end
      end else m_age++;
    end else if (req_bit(req, m_own) == 0) begin
      if (m_age < H) begin m_rel = 1; m_age++; end
      else begin
        w = pick(req, m_ptr, m_own);
        if (w >= 0) grab(w);
        else begin m_have = 0; m_vld = 1'b0; end
      end
    end else begin
      w = (m_age >= H) ? pick(req, m_ptr, m_own) : -1;
      if (w >= 0) grab(w);
      else begin
        m_val = byte_of(req_data, m_own);
        if (m_age < H) m_age++;
      end
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge CLK) begin
    logic [N-1:0] e_grant;
    e_grant = (m_have == 1 && m_rel == 0) ? N'(1 << m_own) : '0;
    chk("grant",      32'(grant),      32'(e_grant));
    chk("owner",      32'(owner),      32'(m_own));
    chk("disp_value", 32'(disp_value), 32'(m_val));
    chk("disp_valid", 32'(disp_valid), 32'(m_vld));
  end

  task automatic run(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    run(n);
    RST = 1'b0;
  endtask

  initial begin
    logic [N-1:0] flip;
    req_data = $urandom;
    req = 4'b1111;
    // reset with all requesting, then restart from index 0
    run(2);
    RST = 1'b0;
    run(3);
    // single owner, data change tracked with one-cycle latency
    do_reset(1);
    req = 4'b0100;
    req_data[23:16] = 8'hA5;
    run(3);
    req_data[23:16] = 8'h3C;
    run(8);
    // preemption of owner 0 by requester 1
    do_reset(1);
    req = 4'b0001;
    run(1);
    req = 4'b0011;
    req_data = $urandom;
    run(12);
    // linger on owner 3, with its request reasserted mid-linger
    do_reset(1);
    req = 4'b1000;
    run(2);
    req = 4'b0000;
    run(2);
    req = 4'b1000;
    run(6);
    req = 4'b0000;
    run(4);
    // fairness with everyone requesting
    do_reset(1);
    req = 4'b1111;
    run(22);
    // reset while requester 1 owns
    do_reset(1);
    run(7);
    do_reset(1);
    run(6);
    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      flip = '0;
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) flip = flip | N'(1 << b);
      req      = req ^ flip;
      req_data = $urandom;
      RST      = ($urandom_range(0, 199) == 0);
      run(1);
    end
    RST = 1'b0;
    run(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
